// File: rtl/dmem_defs_pkg.sv
// Shared data-memory definitions: responder FSM encodings, latency bounds
// and the latency down-counter width. The hart-side memory stage imports
// this too, so changes here affect both ends of the interface.
package dmem_defs;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Value loaded into the down-counter on entering WAIT.
  function automatic logic [CNT_W-1:0] cnt_load(input int latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/dmem_storage.sv
// Single-port word storage with byte-lane writes and a synchronous read
// into a hold register. Contents are deliberately not reset.
module dmem_storage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_mask,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] hold_q;
  logic [31:0] hold_d;

  // Hold register only moves on an accepted read, so it stays put otherwise.
  always_comb begin
    hold_d = hold_q;
    if (i_re) hold_d = mem_q[i_addr];
  end

  // Lane-masked write and read capture share the acceptance edge.
  always_ff @(posedge i_clk) begin
    hold_q <= hold_d;
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_mask[b]) mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = hold_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed response latency.
// Optional feature macro DMEM_RANGE_CHECK_EN: out-of-range addresses get
// err=1 with no storage access; without it the word index wraps.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no request outstanding, ready=1
// ST_WAIT | request accepted, counting down to response, ready=0
// ST_RESP | response strobe this cycle, ready=1 (back-to-back allowed)
module dmem_responder
  import dmem_defs::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             pend_rd_q, pend_rd_d;
  logic             pend_err_q, pend_err_d;
  logic [31:0]      last_rdata_q, last_rdata_d;

  logic [31:0] off;
  logic        range_err;
  logic        accept;
  logic        do_read;
  logic        do_write;
  logic [31:0] hold_rdata;
  logic        unused_off_bits;

  assign off = i_req_addr - BASE_ADDR;

`ifdef DMEM_RANGE_CHECK_EN
  assign range_err = (i_req_addr < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH_WORDS));
`else
  assign range_err = 1'b0;
`endif

  assign unused_off_bits = ^{off[1:0], off[31:AW+2]};

  assign accept   = ready_q & (i_req_ren | i_req_wen);
  assign do_read  = accept & i_req_ren & ~i_req_wen & ~range_err;
  assign do_write = accept & i_req_wen & ~i_req_ren & ~range_err;

  dmem_storage #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_storage (
    .i_clk   (i_clk),
    .i_we    (do_write),
    .i_re    (do_read),
    .i_addr  (off[AW+1:2]),
    .i_wdata (i_req_wdata),
    .i_mask  (i_req_mask),
    .o_rdata (hold_rdata)
  );

  // Response data is shown only in the strobe cycle and latched for holding.
  assign o_rsp_rdata = valid_q ? (pend_rd_q ? hold_rdata : 32'h0) : last_rdata_q;
  assign o_rsp_err   = valid_q & pend_err_q;
  assign o_rsp_valid = valid_q;
  assign o_req_ready = ready_q;

  // Next-state, counter and response-qualifier computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ready_d      = ready_q;
    valid_d      = 1'b0;
    pend_rd_d    = pend_rd_q;
    pend_err_d   = pend_err_q;
    last_rdata_d = valid_q ? o_rsp_rdata : last_rdata_q;
    if (accept) begin
      pend_rd_d  = do_read;
      pend_err_d = (i_req_ren & i_req_wen) | range_err;
    end
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            valid_d = 1'b1;
            ready_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT;
            ready_d = 1'b0;
            cnt_d   = cnt_load(LATENCY);
          end
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and registered outputs; reset drops any in-flight response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      pend_rd_q    <= 1'b0;
      pend_err_q   <= 1'b0;
      last_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      valid_q      <= valid_d;
      pend_rd_q    <= pend_rd_d;
      pend_err_q   <= pend_err_d;
      last_rdata_q <= last_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance a uses LATENCY=2,
// instance b uses LATENCY=1; expectations follow DMEM_RANGE_CHECK_EN.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
  logic        a_ren, a_wen, a_ready, a_valid, a_err;
  logic        b_ren, b_wen, b_ready, b_valid, b_err;
  logic [3:0]  a_mask, b_mask;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_addr(a_addr), .i_req_ren(a_ren),
    .i_req_wen(a_wen), .i_req_wdata(a_wdata), .i_req_mask(a_mask),
    .o_req_ready(a_ready), .o_rsp_valid(a_valid), .o_rsp_rdata(a_rdata),
    .o_rsp_err(a_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_addr(b_addr), .i_req_ren(b_ren),
    .i_req_wen(b_wen), .i_req_wdata(b_wdata), .i_req_mask(b_mask),
    .o_req_ready(b_ready), .o_rsp_valid(b_valid), .o_rsp_rdata(b_rdata),
    .o_rsp_err(b_err)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] prev_a = 32'h0;
  logic [31:0] prev_b = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel_b, input logic [31:0] addr, input logic ren,
                       input logic wen, input logic [31:0] wdata, input logic [3:0] mask);
    if (sel_b) begin
      b_addr = addr; b_ren = ren; b_wen = wen; b_wdata = wdata; b_mask = mask;
    end else begin
      a_addr = addr; a_ren = ren; a_wen = wen; a_wdata = wdata; a_mask = mask;
    end
  endtask

  // One request, waits for its strobe, checks latency, data, error and hold.
  task automatic xfer(input bit sel_b, input logic [31:0] addr, input logic ren,
                      input logic wen, input logic [31:0] wdata, input logic [3:0] mask,
                      input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int          lat;
    int          n;
    bit          got;
    logic [31:0] prev;
    lat  = sel_b ? 1 : 2;
    n    = 0;
    got  = 1'b0;
    prev = sel_b ? prev_b : prev_a;
    @(negedge clk);
    check({tag, ".ready"}, {31'b0, sel_b ? b_ready : a_ready}, 32'd1);
    drive(sel_b, addr, ren, wen, wdata, mask);
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) drive(sel_b, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
      if (sel_b ? b_valid : a_valid) got = 1'b1;
      else check({tag, ".hold_wait"}, sel_b ? b_rdata : a_rdata, prev);
    end
    check({tag, ".latency"}, 32'(n), 32'(lat));
    check({tag, ".rdata"}, sel_b ? b_rdata : a_rdata, exp_rdata);
    check({tag, ".err"}, {31'b0, sel_b ? b_err : a_err}, {31'b0, exp_err});
    @(negedge clk);
    check({tag, ".strobe_len"}, {31'b0, sel_b ? b_valid : a_valid}, 32'd0);
    check({tag, ".hold_after"}, sel_b ? b_rdata : a_rdata, exp_rdata);
    if (sel_b) prev_b = exp_rdata;
    else       prev_a = exp_rdata;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    check("rst.valid", {31'b0, a_valid}, 32'd0);
    check("rst.rdata", a_rdata, 32'h0);
    check("rst.err",   {31'b0, a_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.ready", {31'b0, a_ready}, 32'd1);

    xfer(1'b0, 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "wr_beef");
    xfer(1'b0, 32'h10, 1'b1, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, "rd_beef");

    xfer(1'b0, 32'h10, 1'b0, 1'b1, 32'h11223344, 4'hF, 32'h0, 1'b0, "wr_base");
    xfer(1'b0, 32'h12, 1'b0, 1'b1, 32'hAB000000, 4'h8, 32'h0, 1'b0, "wr_lane3");
    xfer(1'b0, 32'h10, 1'b1, 1'b0, 32'h0,        4'h1, 32'hAB223344, 1'b0, "rd_lane3");

    xfer(1'b0, 32'h20, 1'b0, 1'b1, 32'h12345678, 4'hF, 32'h0, 1'b0, "wr_w8");
    xfer(1'b0, 32'h20, 1'b1, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "conflict");
    xfer(1'b0, 32'h20, 1'b1, 1'b0, 32'h0,        4'hF, 32'h12345678, 1'b0, "rd_w8");

    xfer(1'b0, 32'h24, 1'b0, 1'b1, 32'h11111111, 4'hF, 32'h0, 1'b0, "wr_w9");
    xfer(1'b0, 32'h24, 1'b0, 1'b1, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, "wr_mask0");
    xfer(1'b0, 32'h24, 1'b1, 1'b0, 32'h0,        4'hF, 32'h11111111, 1'b0, "rd_mask0");

    xfer(1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "wr_w0");
`ifdef DMEM_RANGE_CHECK_EN
    xfer(1'b0, 32'h1000, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, "rd_oob");
    xfer(1'b0, 32'h1000, 1'b0, 1'b1, 32'h0BADBAD0, 4'hF, 32'h0, 1'b1, "wr_oob");
    xfer(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, "rd_w0_kept");
`else
    xfer(1'b0, 32'h1000, 1'b1, 1'b0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, "rd_wrap");
`endif

    // LATENCY=1: back-to-back reads issued during the response cycle.
    xfer(1'b1, 32'h0, 1'b0, 1'b1, 32'h01020304, 4'hF, 32'h0, 1'b0, "b_wr0");
    xfer(1'b1, 32'h4, 1'b0, 1'b1, 32'hA5A55A5A, 4'hF, 32'h0, 1'b0, "b_wr1");
    @(negedge clk);
    drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    check("b2b.valid0", {31'b0, b_valid}, 32'd1);
    check("b2b.rdata0", b_rdata, 32'h01020304);
    check("b2b.ready0", {31'b0, b_ready}, 32'd1);
    drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    check("b2b.valid1", {31'b0, b_valid}, 32'd1);
    check("b2b.rdata1", b_rdata, 32'hA5A55A5A);
    check("b2b.ready1", {31'b0, b_ready}, 32'd1);
    @(negedge clk);
    check("b2b.idle", {31'b0, b_valid}, 32'd0);
    check("b2b.hold", b_rdata, 32'hA5A55A5A);

    // Reset during WAIT: response dropped, committed write survives.
    @(negedge clk);
    drive(1'b0, 32'h8, 1'b0, 1'b1, 32'h00000055, 4'hF);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    check("rstw.in_wait", {31'b0, a_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("rstw.valid", {31'b0, a_valid}, 32'd0);
    check("rstw.rdata", a_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstw.no_rsp", {31'b0, a_valid}, 32'd0);
    end
    check("rstw.ready", {31'b0, a_ready}, 32'd1);
    prev_a = 32'h0;
    prev_b = 32'h0;
    xfer(1'b0, 32'h8, 1'b1, 1'b0, 32'h0, 4'hF, 32'h00000055, 1'b0, "rstw.rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words (power of two, ≥4).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h00000000, byte address of word 0 (word aligned).
REQ-004 SHALL have one clock and a reset: i_clk  in  1  global clock, rising edge; i_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have i_req_addr  in  32  byte address; bits [1:0] ignored.
REQ-006 SHALL have i_req_ren  in  1  read request.
REQ-007 SHALL have i_req_wen  in  1  write request.
REQ-008 SHALL have i_req_wdata  in  32  write data, already lane-shifted by the hart.
REQ-009 SHALL have i_req_mask  in  4  byte-lane enables; bit n selects wdata[8n+7:8n].
REQ-010 SHALL have o_req_ready  out  1  request may be accepted this cycle.
REQ-011 SHALL have o_rsp_valid  out  1  single-cycle response strobe.
REQ-012 SHALL have o_rsp_rdata  out  32  read word; valid while o_rsp_valid is high.
REQ-013 SHALL have o_rsp_err  out  1  error flag qualified by o_rsp_valid.

Function
REQ-014 SHALL accept a request on a rising edge where o_req_ready=1 and (i_req_ren|i_req_wen)=1; one request outstanding at most.
REQ-015 SHALL implement FSM IDLE→WAIT→RESP→IDLE; IDLE: ready=1; WAIT: ready=0, down-counter loaded with LATENCY-1; RESP: rsp_valid=1, ready=1.
REQ-016 SHALL skip WAIT when LATENCY=1 (IDLE→RESP directly); for LATENCY=N, o_rsp_valid SHALL be high in exactly the Nth cycle after the acceptance edge.
REQ-017 SHALL accept a new request in RESP (back-to-back) and go to WAIT/RESP per REQ-016; with no request, RESP→IDLE.
REQ-018 SHALL compute word index = (i_req_addr - BASE_ADDR) >> 2.
REQ-019 SHALL commit writes at the acceptance edge, updating only masked lanes; mask 4'b0000 writes nothing and still responds.
REQ-020 SHALL sample the read word at the acceptance edge into a hold register; reads return all 32 bits regardless of mask.
REQ-021 SHALL hold o_rsp_rdata stable from the response cycle until the next response; write responses drive o_rsp_rdata=0.
REQ-022 SHALL treat ren&wen together as a no-op: no storage access, response issued with rdata=0 and err=1.
REQ-023 SHALL ignore requests while ready=0; the bench must hold them (no queueing).

Reset
REQ-024 SHALL on i_rst force, immediately: state IDLE, counter 0, o_rsp_valid 0, o_rsp_rdata 0, o_rsp_err 0, and o_req_ready 1 once reset deasserts.
REQ-025 SHALL drop any in-flight response on reset mid-operation; a write committed at acceptance remains in storage; storage contents are not reset.

Configuration
REQ-026 SHALL honour macro DMEM_RANGE_CHECK_EN. When defined: index ≥ DEPTH_WORDS or address below BASE_ADDR yields a response with err=1, rdata=0, and no write. When undefined: index wraps modulo DEPTH_WORDS, err is 1 only per REQ-022.

Structure
REQ-027 SHALL place FSM state encodings, the LATENCY bounds and counter width in the shared dmem_defs package, which the hart-side memory stage also uses.
REQ-028 SHALL instantiate one sub-module dmem_storage (single port, byte-lane write, synchronous read into hold register); FSM and range logic stay in dmem_responder.

Verification
REQ-029 Write addr 0x10, wdata 0xDEADBEEF, mask 4'hF, then read 0x10 (LATENCY=2) → rsp_valid exactly 2 cycles after each acceptance; rdata 0xDEADBEEF, err 0.
REQ-030 Write 0x12 wdata 0xAB000000 mask 4'b1000 over 0x11223344, read 0x10 → rdata 0xAB223344.
REQ-031 Back-to-back reads 0x0, 0x4 issued in RESP (LATENCY=1) → rsp_valid high on two consecutive cycles with the correct words; ready never low.
REQ-032 ren=wen=1 at 0x20 → no write to word 8; response with err=1, rdata 0.
REQ-033 Read 0x1000 with DEPTH_WORDS=1024: with DMEM_RANGE_CHECK_EN → err=1, rdata 0; without → returns word 0, err 0.
REQ-034 Assert i_rst during WAIT after a write of 0x55 to 0x8 → no rsp_valid; ready=1 after reset release; later read 0x8 → 0x55.
